// File: rtl/spi_slave_ctrl.sv
// SPI slave register-access controller: address + R/W header, then one data word read or written.
// Optional SPI_SLAVE_BURST_EN: keep transferring auto-incremented words while cs_n stays low.
module spi_slave_ctrl #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              sclk_pe,
    input  logic              sclk_ne,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data
);
    localparam int unsigned SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_LOAD,
        RD_SHIFT,
        WR_SHIFT,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [SH_W-1:0]   shreg, shreg_d;
    logic [SH_W-1:0]   shreg_in;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [DATA_W-1:0] wr_word;
    logic              wr_en_d;
    logic              rd_req_d;
    logic              miso_d;
    logic              miso_oe_d;
    logic              inc_pend, inc_pend_d;
    logic              word_last;

    assign shreg_in  = {shreg[SH_W-2:0], mosi};
    assign wr_word   = shreg_in[DATA_W-1:0];
    assign word_last = (cnt == CNT_W'(DATA_W - 1));

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            addr     <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
            rd_req   <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            inc_pend <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            shreg    <= shreg_d;
            addr     <= addr_d;
            wr_data  <= wr_data_d;
            wr_en    <= wr_en_d;
            rd_req   <= rd_req_d;
            miso     <= miso_d;
            miso_oe  <= miso_oe_d;
            inc_pend <= inc_pend_d;
        end
    end

    // Next-state and next-output logic; cs_n high overrides everything
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        shreg_d    = shreg;
        addr_d     = addr;
        wr_data_d  = wr_data;
        wr_en_d    = 1'b0;
        rd_req_d   = 1'b0;
        inc_pend_d = 1'b0;
        miso_oe_d  = 1'b0;
        miso_d     = 1'b0;

        // Burst writes advance addr one cycle late so wr_en sees the word's own address
        if (inc_pend) begin
            addr_d = addr + ADDR_W'(1);
        end

        if (cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
                ADDR: begin
                    if (sclk_pe) begin
                        if (cnt == CNT_W'(ADDR_W)) begin
                            addr_d  = shreg[ADDR_W-1:0];
                            cnt_d   = '0;
                            state_d = mosi ? RD_LOAD : WR_SHIFT;
                        end else begin
                            shreg_d = shreg_in;
                            cnt_d   = cnt + CNT_W'(1);
                        end
                    end
                end
                RD_LOAD: begin
                    // cnt 0: raise rd_req; cnt 1: rd_req high; cnt 2: rd_data valid, load it
                    rd_req_d = (cnt == '0);
                    cnt_d    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(2)) begin
                        shreg_d = SH_W'(rd_data);
                        cnt_d   = '0;
                        state_d = RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    if (sclk_ne) begin
                        shreg_d = shreg << 1;
                        cnt_d   = cnt + CNT_W'(1);
                        if (word_last) begin
                            cnt_d = '0;
                            if (BURST_EN) begin
                                addr_d  = addr + ADDR_W'(1);
                                state_d = RD_LOAD;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                WR_SHIFT: begin
                    if (sclk_pe) begin
                        shreg_d = shreg_in;
                        cnt_d   = cnt + CNT_W'(1);
                        if (word_last) begin
                            cnt_d     = '0;
                            wr_data_d = wr_word;
                            wr_en_d   = 1'b1;
                            if (BURST_EN) begin
                                inc_pend_d = 1'b1;
                                state_d    = WR_SHIFT;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        miso_oe_d = (state_d == RD_SHIFT);
        miso_d    = miso_oe_d & shreg_d[DATA_W-1];
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed frames plus randomized transactions
// against a transaction-level model (expected addr/data/bit sequences).
module tb_spi_slave_ctrl;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
`ifdef SPI_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs_n    = 1'b1;
    logic          sclk_pe = 1'b0;
    logic          sclk_ne = 1'b0;
    logic          mosi    = 1'b0;
    logic          miso;
    logic          miso_oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          rd_req;
    logic [DW-1:0] rd_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: last committed address and write word, plus the register file read source
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wr_data = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Observations collected by the monitor
    int            cyc         = 0;
    int            last_pe_cyc = 0;
    int            miso_leak   = 0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wdel_q[$];
    logic [AW-1:0] ra_q[$];
    bit            miso_q[$];
    bit            rd_hit = 1'b0;
    logic [AW-1:0] rd_hit_addr = '0;

    spi_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs_n    (cs_n),
        .sclk_pe (sclk_pe),
        .sclk_ne (sclk_ne),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .addr    (addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_req  (rd_req),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (sclk_pe) last_pe_cyc = cyc;
        if (wr_en) begin
            wa_q.push_back(addr);
            wd_q.push_back(wr_data);
            wdel_q.push_back(cyc - last_pe_cyc);
        end
        rd_hit = rd_req;
        if (rd_req) begin
            ra_q.push_back(addr);
            rd_hit_addr = addr;
        end
        if (sclk_ne && miso_oe) miso_q.push_back(miso);
        if (!miso_oe && miso) miso_leak++;
    end

    // rd_data carries the addressed word only in the cycle after rd_req, garbage otherwise
    always @(posedge clk) begin
        #2;
        rd_data = rd_hit ? mem[rd_hit_addr] : DW'($urandom);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        wa_q.delete();
        wd_q.delete();
        wdel_q.delete();
        ra_q.delete();
        miso_q.delete();
    endtask

    task automatic sclk_cycle(input bit b, input int tail);
        mosi    = b;
        sclk_pe = 1'b1;
        tick();
        sclk_pe = 1'b0;
        tick(5);
        sclk_ne = 1'b1;
        tick();
        sclk_ne = 1'b0;
        tick(tail);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        cs_n = 1'b1;
        tick(4);
    endtask

    task automatic send_header(input logic [AW-1:0] a, input bit rd);
        for (int i = AW - 1; i >= 0; i--) sclk_cycle(a[i], 5);
        sclk_cycle(rd, 5);
    endtask

    // nbits data bits of d, MSB first; coincide raises cs_n together with the last sclk_pe
    task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int nbits, input bit coincide);
        cs_start();
        send_header(a, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (coincide && i == nbits - 1) begin
                mosi    = d[DW-1-i];
                sclk_pe = 1'b1;
                cs_n    = 1'b1;
                tick();
                sclk_pe = 1'b0;
                tick(3);
            end else begin
                sclk_cycle(d[DW-1-i], 5);
            end
        end
        cs_end();
    endtask

    // The R/W bit's falling edge is the first of the DW read falling edges
    task automatic read_frame(input logic [AW-1:0] a);
        cs_start();
        send_header(a, 1'b1);
        for (int i = 0; i < DW - 1; i++) sclk_cycle(1'($urandom), (i == DW - 2) ? 0 : 5);
        cs_end();
    endtask

    function automatic logic [DW-1:0] miso_word();
        logic [DW-1:0] w;
        w = '0;
        foreach (miso_q[i]) w = {w[DW-2:0], miso_q[i]};
        return w;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cs_n    = 1'b1;
        tick(3);
        n_cmp += 6;
        if (miso !== 1'b0)    begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
        if (addr !== '0)      begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr); end
        if (wr_data !== '0)   begin n_fail++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        if (rd_req !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_req got=%b exp=0", rd_req); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write();
        clear_obs();
        write_frame(7'h2A, 8'hC3, 8, 1'b0);
        m_wr_data = 8'hC3;
        m_addr    = BURST ? 7'h2B : 7'h2A;
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_fail++; $display("FAIL write_count got=%0d exp=1", wa_q.size());
        end else begin
            n_cmp += 3;
            if (wa_q[0] !== 7'h2A) begin n_fail++; $display("FAIL write_addr got=%h exp=2a", wa_q[0]); end
            if (wd_q[0] !== 8'hC3) begin n_fail++; $display("FAIL write_data got=%h exp=c3", wd_q[0]); end
            if (wdel_q[0] != 1)    begin n_fail++; $display("FAIL write_delay got=%0d exp=1", wdel_q[0]); end
        end
        n_cmp += 2;
        if (addr !== m_addr)       begin n_fail++; $display("FAIL write_addr_out got=%h exp=%h", addr, m_addr); end
        if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL write_wr_data got=%h exp=%h", wr_data, m_wr_data); end
    endtask

    task automatic test_read();
        clear_obs();
        mem[5] = 8'h96;
        read_frame(7'h05);
        m_addr = BURST ? 7'h06 : 7'h05;
        n_cmp += 5;
        if (ra_q.size() != 1) begin n_fail++; $display("FAIL read_rd_req_count got=%0d exp=1", ra_q.size()); end
        else if (ra_q[0] !== 7'h05) begin n_fail++; $display("FAIL read_rd_addr got=%h exp=05", ra_q[0]); end
        if (miso_q.size() != DW) begin n_fail++; $display("FAIL read_bit_count got=%0d exp=%0d", miso_q.size(), DW); end
        if (miso_word() !== 8'h96) begin n_fail++; $display("FAIL read_miso_seq got=%h exp=96", miso_word()); end
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_after got=%b exp=0", miso_oe); end
        if (addr !== m_addr)  begin n_fail++; $display("FAIL read_addr_out got=%h exp=%h", addr, m_addr); end
    endtask

    task automatic test_abort();
        clear_obs();
        write_frame(7'h11, 8'h5A, 4, 1'b0);
        m_addr = 7'h11;
        n_cmp += 4;
        if (wa_q.size() != 0)      begin n_fail++; $display("FAIL abort_wr_en got=%0d exp=0", wa_q.size()); end
        if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL abort_wr_data got=%h exp=%h", wr_data, m_wr_data); end
        if (addr !== m_addr)       begin n_fail++; $display("FAIL abort_addr got=%h exp=%h", addr, m_addr); end
        if (miso_oe !== 1'b0)      begin n_fail++; $display("FAIL abort_oe got=%b exp=0", miso_oe); end
    endtask

    task automatic test_coincide();
        clear_obs();
        write_frame(7'h33, 8'hE7, 8, 1'b1);
        m_addr = 7'h33;
        n_cmp += 3;
        if (wa_q.size() != 0)      begin n_fail++; $display("FAIL coincide_wr_en got=%0d exp=0", wa_q.size()); end
        if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL coincide_wr_data got=%h exp=%h", wr_data, m_wr_data); end
        if (addr !== m_addr)       begin n_fail++; $display("FAIL coincide_addr got=%h exp=%h", addr, m_addr); end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] d;
        clear_obs();
        mem[7'h44] = 8'hA5;
        cs_start();
        send_header(7'h44, 1'b1);
        sclk_cycle(1'b0, 5);
        sclk_cycle(1'b0, 5);
        n_cmp++;
        if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL midread_oe_before got=%b exp=1", miso_oe); end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        m_addr    = '0;
        m_wr_data = '0;
        n_cmp += 6;
        if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL midread_oe got=%b exp=0", miso_oe); end
        if (miso !== 1'b0)    begin n_fail++; $display("FAIL midread_miso got=%b exp=0", miso); end
        if (addr !== '0)      begin n_fail++; $display("FAIL midread_addr got=%h exp=0", addr); end
        if (wr_data !== '0)   begin n_fail++; $display("FAIL midread_wr_data got=%h exp=0", wr_data); end
        if (wr_en !== 1'b0)   begin n_fail++; $display("FAIL midread_wr_en got=%b exp=0", wr_en); end
        if (rd_req !== 1'b0)  begin n_fail++; $display("FAIL midread_rd_req got=%b exp=0", rd_req); end
        // Release reset with cs_n still low: the very next bits form a fresh header
        tick(2);
        reset_n = 1'b1;
        clear_obs();
        d = 8'h3D;
        write_frame(7'h6C, d, 8, 1'b0);
        m_wr_data = d;
        m_addr    = BURST ? 7'h6D : 7'h6C;
        n_cmp++;
        if (wa_q.size() != 1) begin
            n_fail++; $display("FAIL postreset_count got=%0d exp=1", wa_q.size());
        end else begin
            n_cmp += 2;
            if (wa_q[0] !== 7'h6C) begin n_fail++; $display("FAIL postreset_addr got=%h exp=6c", wa_q[0]); end
            if (wd_q[0] !== d)     begin n_fail++; $display("FAIL postreset_data got=%h exp=%h", wd_q[0], d); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit            rd;
            int            nbits;
            a  = AW'($urandom);
            d  = DW'($urandom);
            rd = 1'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
            clear_obs();
            if (rd) begin
                read_frame(a);
                m_addr = BURST ? AW'(a + 1) : a;
                n_cmp += 2;
                if (ra_q.size() != 1 || ra_q[0] !== a) begin
                    n_fail++; $display("FAIL rand_rd_req it=%0d got_n=%0d exp_addr=%h", it, ra_q.size(), a);
                end
                if (miso_q.size() != DW || miso_word() !== mem[a]) begin
                    n_fail++; $display("FAIL rand_miso it=%0d got=%h exp=%h", it, miso_word(), mem[a]);
                end
            end else begin
                write_frame(a, d, nbits, 1'b0);
                n_cmp++;
                if (nbits == DW) begin
                    m_wr_data = d;
                    m_addr    = BURST ? AW'(a + 1) : a;
                    if (wa_q.size() != 1 || wa_q[0] !== a || wd_q[0] !== d || wdel_q[0] != 1) begin
                        n_fail++; $display("FAIL rand_write it=%0d got_n=%0d exp a=%h d=%h", it, wa_q.size(), a, d);
                    end
                end else begin
                    m_addr = a;
                    if (wa_q.size() != 0) begin
                        n_fail++; $display("FAIL rand_abort it=%0d got_n=%0d exp=0", it, wa_q.size());
                    end
                end
            end
            n_cmp += 2;
            if (addr !== m_addr)       begin n_fail++; $display("FAIL rand_addr it=%0d got=%h exp=%h", it, addr, m_addr); end
            if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL rand_wr_data it=%0d got=%h exp=%h", it, wr_data, m_wr_data); end
        end
    endtask

    task automatic test_burst();
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        d1 = DW'($urandom);
        d2 = DW'($urandom);
        clear_obs();
        cs_start();
        send_header(7'h7F, 1'b0);
        for (int i = 0; i < DW; i++) sclk_cycle(d1[DW-1-i], 5);
        for (int i = 0; i < DW; i++) sclk_cycle(d2[DW-1-i], 5);
        cs_end();
        n_cmp++;
        if (BURST) begin
            m_addr    = 7'h01;
            m_wr_data = d2;
            if (wa_q.size() != 2 || wa_q[0] !== 7'h7F || wd_q[0] !== d1 || wa_q[1] !== 7'h00 || wd_q[1] !== d2) begin
                n_fail++; $display("FAIL burst_writes got_n=%0d exp=2 (7f:%h, 00:%h)", wa_q.size(), d1, d2);
            end
        end else begin
            m_addr    = 7'h7F;
            m_wr_data = d1;
            if (wa_q.size() != 1 || wa_q[0] !== 7'h7F || wd_q[0] !== d1) begin
                n_fail++; $display("FAIL burst_single got_n=%0d exp=1 (7f:%h)", wa_q.size(), d1);
            end
        end
        n_cmp += 2;
        if (addr !== m_addr)       begin n_fail++; $display("FAIL burst_addr got=%h exp=%h", addr, m_addr); end
        if (wr_data !== m_wr_data) begin n_fail++; $display("FAIL burst_wr_data got=%h exp=%h", wr_data, m_wr_data); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_coincide();
        test_reset_mid_read();
        test_random();
        test_burst();
        n_cmp++;
        if (miso_leak != 0) begin n_fail++; $display("FAIL miso_without_oe got=%0d exp=0", miso_leak); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
